// File: rtl/receive_instr.sv
// Instruction receiver: frames the transmitter stream on START/STOP marker words and
// buffers the payload in a fall-through FIFO. The sync request is throttled so the FIFO never overflows.
module receive_instr #(
   parameter int          IWIDTH     = 32,
   parameter int          DEPTH      = 16,
   parameter logic [31:0] START_WORD = 32'hAAAA_AAAA,
   parameter logic [31:0] STOP_WORD  = 32'h5555_5555
) (
   input  logic                     r_clk,
   input  logic                     r_rst,
   input  logic                     r_i_start,
   input  logic [IWIDTH-1:0]        r_i_instr,
   input  logic                     r_i_ack,
   output logic                     r_o_syn,
   input  logic                     r_i_rd_en,
   output logic [IWIDTH-1:0]        r_o_instr,
   output logic                     r_o_valid,
   output logic [$clog2(DEPTH):0]   r_o_count,
   output logic                     r_o_done,
   output logic                     r_o_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HUNT = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [IWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic [1:0]        w_state_nxt;
   logic [CW-1:0]     w_count_nxt;
   logic              w_is_start;
   logic              w_is_stop;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_write;
   logic              w_ovf;

   assign w_is_start = (r_i_instr == IWIDTH'(START_WORD));
   assign w_is_stop  = (r_i_instr == IWIDTH'(STOP_WORD));

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = r_i_rd_en && (r_count != '0);
   assign w_push  = (r_state == S_LOAD) && r_i_ack && !w_is_stop;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the word.
   assign w_write = w_push && (!w_full || w_pop);
   assign w_ovf   = w_push && w_full && !w_pop;

   always_comb begin
      w_count_nxt = r_count;
      if (w_write && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (!w_write && w_pop) w_count_nxt = r_count - CW'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (r_i_start)              w_state_nxt = S_HUNT;
         S_HUNT: if (r_i_ack && w_is_start)  w_state_nxt = S_LOAD;
         S_LOAD: if (r_i_ack && w_is_stop)   w_state_nxt = S_DONE;
         S_DONE: if (r_count == '0)          w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_o_syn  <= 1'b0;
         r_o_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_ovf)   r_o_err  <= 1'b1;
         // Two free slots absorb the ack the transmitter may still return after syn falls.
         r_o_syn <= ((w_state_nxt == S_HUNT) || (w_state_nxt == S_LOAD)) &&
                    (w_count_nxt <= CW'(DEPTH - 3));
      end
   end

   always_ff @(posedge r_clk) begin
      if (!r_rst && w_write) r_mem[r_wr_ptr] <= r_i_instr;
   end

   assign r_o_valid = (r_count != '0);
   assign r_o_instr = r_o_valid ? r_mem[r_rd_ptr] : '0;
   assign r_o_count = r_count;
   assign r_o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_receive_instr.sv
// Bench for receive_instr: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the framing and FIFO rules.
module tb_receive_instr;
   localparam int          IW    = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] STW   = 32'hAAAA_AAAA;
   localparam logic [31:0] SPW   = 32'h5555_5555;

   logic          r_clk = 1'b0;
   logic          r_rst, r_i_start, r_i_ack, r_i_rd_en;
   logic [IW-1:0] r_i_instr;
   logic          r_o_syn, r_o_valid, r_o_done, r_o_err;
   logic [IW-1:0] r_o_instr;
   logic [4:0]    r_o_count;

   always #5 r_clk = ~r_clk;

   receive_instr dut (
      .r_clk(r_clk), .r_rst(r_rst), .r_i_start(r_i_start), .r_i_instr(r_i_instr),
      .r_i_ack(r_i_ack), .r_o_syn(r_o_syn), .r_i_rd_en(r_i_rd_en), .r_o_instr(r_o_instr),
      .r_o_valid(r_o_valid), .r_o_count(r_o_count), .r_o_done(r_o_done), .r_o_err(r_o_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model
   typedef enum {M_IDLE, M_HUNT, M_LOAD, M_DONE} mst_t;
   mst_t        m_st  = M_IDLE;
   logic [31:0] q[$];
   bit          m_err = 0;
   bit          m_syn = 0;

   task automatic model(input bit st, input bit ack, input logic [31:0] w, input bit rd, input bit rs);
      bit   pop, push, full;
      mst_t nst;
      if (rs) begin
         q.delete(); m_st = M_IDLE; m_err = 0; m_syn = 0;
         return;
      end
      full = (q.size() == DEPTH);
      pop  = rd && (q.size() > 0);
      push = (m_st == M_LOAD) && ack && (w != SPW);
      nst  = m_st;
      case (m_st)
         M_IDLE: if (st) nst = M_HUNT;
         M_HUNT: if (ack && w == STW) nst = M_LOAD;
         M_LOAD: if (ack && w == SPW) nst = M_DONE;
         M_DONE: if (q.size() == 0) nst = M_IDLE;
         default: nst = M_IDLE;
      endcase
      if (pop) void'(q.pop_front());
      if (push) begin
         if (full && !pop) m_err = 1;
         else q.push_back(w);
      end
      m_st  = nst;
      m_syn = (nst == M_HUNT || nst == M_LOAD) && (q.size() <= DEPTH - 3);
   endtask

   task automatic check_all();
      chk("count", 32'(r_o_count), 32'(q.size()));
      chk("valid", 32'(r_o_valid), 32'(q.size() != 0));
      chk("instr", r_o_instr, (q.size() != 0) ? q[0] : 32'h0);
      chk("syn",   32'(r_o_syn),   32'(m_syn));
      chk("done",  32'(r_o_done),  32'(m_st == M_DONE));
      chk("err",   32'(r_o_err),   32'(m_err));
   endtask

   task automatic step(input bit st, input bit ack, input logic [31:0] w, input bit rd, input bit rs);
      r_i_start = st; r_i_ack = ack; r_i_instr = w; r_i_rd_en = rd; r_rst = rs;
      @(posedge r_clk);
      model(st, ack, w, rd, rs);
      #1;
      check_all();
   endtask

   // transmitter: waits (bounded) for syn, then returns one acked word
   task automatic send(input logic [31:0] w);
      int t = 0;
      while (!r_o_syn && t < 50) begin
         step(0, 0, 32'h0, 0, 0);
         t++;
      end
      chk("syn_wait", 32'(r_o_syn), 32'h1);
      step(0, 1, w, 0, 0);
   endtask

   function automatic logic [31:0] data_word();
      return $urandom & 32'h0FFF_FFFF;
   endfunction

   initial begin
      r_rst = 1; r_i_start = 0; r_i_ack = 0; r_i_instr = '0; r_i_rd_en = 0;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("rst_syn", 32'(r_o_syn), 32'h0);

      // basic frame
      step(1, 0, 0, 0, 0);
      send(STW); send(32'h0000_0013); send(32'h0010_0093); send(SPW);
      chk("frame_count", 32'(r_o_count), 32'd2);
      chk("frame_done",  32'(r_o_done),  32'h1);
      chk("frame_head",  r_o_instr,      32'h0000_0013);
      step(0, 0, 0, 1, 0);
      chk("frame_head2", r_o_instr,      32'h0010_0093);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("frame_idle",  32'(r_o_done),  32'h0);

      // garbage before START is discarded
      step(1, 0, 0, 0, 0);
      send(32'h1234_5678); send(SPW);
      chk("hunt_count", 32'(r_o_count), 32'd0);
      send(STW); send(32'h0000_0042);
      chk("hunt_load",  32'(r_o_count), 32'd1);

      // fill without pops: syn throttles at DEPTH-2, then forced acks overflow
      for (int i = 0; i < 30; i++) step(0, r_o_syn, data_word(), 0, 0);
      chk("throttle_count", 32'(r_o_count), 32'd14);
      chk("throttle_err",   32'(r_o_err),   32'h0);
      for (int i = 0; i < 3; i++) step(0, 1, data_word(), 0, 0);
      chk("ovf_err",   32'(r_o_err),   32'h1);
      chk("ovf_count", 32'(r_o_count), 32'd16);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
      chk("drain_syn", 32'(r_o_syn), 32'h1);
      chk("err_stick", 32'(r_o_err), 32'h1);
      send(SPW);
      step(0, 0, 0, 0, 0);

      // simultaneous push/pop and pointer wrap
      step(0, 0, 0, 0, 1);
      chk("rst_err", 32'(r_o_err), 32'h0);
      step(1, 0, 0, 0, 0);
      send(STW);
      for (int i = 0; i < 5; i++) send(data_word());
      step(0, 1, data_word(), 1, 0);
      chk("pushpop_count", 32'(r_o_count), 32'd5);
      for (int i = 0; i < 300; i++)
         step(0, r_o_syn & 1'($urandom), data_word(), 1'($urandom), 0);

      // reset mid-load
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      send(STW);
      for (int i = 0; i < 7; i++) send(data_word());
      chk("mid_count", 32'(r_o_count), 32'd7);
      step(0, 1, data_word(), 0, 1);
      chk("mid_rst_count", 32'(r_o_count), 32'd0);
      chk("mid_rst_syn",   32'(r_o_syn),   32'h0);
      step(0, 1, STW, 0, 0);
      step(0, 1, data_word(), 0, 0);
      chk("mid_ignored", 32'(r_o_count), 32'd0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] w;
         case ($urandom_range(0, 5))
            0:       w = STW;
            1:       w = SPW;
            default: w = data_word();
         endcase
         step(($urandom_range(0, 15) == 0), 1'($urandom), w,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
